keypad_scanner: RTL

//  Parametrised ROWS x COLS matrix-keypad scanner with per-column settle time, debounce, ghost rejection,
//  and an event FIFO drained over a valid/ready handshake. Sits between the keypad pins and the calculator

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_evt_fifo.sv | 66 ++++++
 rtl/keypad_scanner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_pkg                                                   |
// | Description : Shared types and key-code constants for the matrix keypad    |
// |               scanner and its consumers (calculator controller).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package keypad_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_HELD     = 2'd2,
        KP_RELEASE  = 2'd3
    } kp_state_t;

    // Widest key code a consumer-side event record can hold
    localparam int KP_CODE_W_MAX = 8;

    // One keypad event as seen by a consumer
    typedef struct packed {
        logic [KP_CODE_W_MAX-1:0] code;
        logic                     is_repeat;
    } kp_event_t;

    // Raw code = row*COLS + col for the standard 4x4 calculator layout
    localparam logic [KP_CODE_W_MAX-1:0] KEY_1     = 8'd0;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_2     = 8'd1;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_3     = 8'd2;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_A     = 8'd3;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_4     = 8'd4;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_5     = 8'd5;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_6     = 8'd6;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_B     = 8'd7;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_7     = 8'd8;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_8     = 8'd9;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_9     = 8'd10;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_C     = 8'd11;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_STAR  = 8'd12;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_0     = 8'd13;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_HASH  = 8'd14;
    localparam logic [KP_CODE_W_MAX-1:0] KEY_D     = 8'd15;

    // Raw key code from matrix position
    function automatic int kp_code(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_evt_fifo                                              |
// | Description : Synchronous FIFO with occupancy count and full/empty flags.  |
// |               Registered storage, no fall-through. A push while full is    |
// |               accepted only when a pop happens in the same cycle.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keypad_evt_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || w_pop);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage; cleared on reset so the head reads 0 while empty after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_scanner                                               |
// | Description : ROWS x COLS matrix keypad scanner: one-cold column drive,    |
// |               settle, debounce, ghost rejection, event FIFO with           |
// |               valid/ready drain and sticky overflow.                       |
// |               Optional auto-repeat: define KEYPAD_AUTOREPEAT_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                            clk,
    input  logic                            RST,
    input  logic [ROWS-1:0]                 row_in,
    output logic [COLS-1:0]                 col_out,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    evt_code,
    output logic                            evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic                            busy
);
    localparam int CODE_W = $clog2(ROWS * COLS);
    localparam int CIDX_W = $clog2(COLS);
    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EVT_W  = CODE_W + 1;
`else
    localparam int EVT_W  = CODE_W;
`endif

    localparam logic [1:0] c_ST_SCAN     = KP_SCAN;
    localparam logic [1:0] c_ST_DEBOUNCE = KP_DEBOUNCE;
    localparam logic [1:0] c_ST_HELD     = KP_HELD;
    localparam logic [1:0] c_ST_RELEASE  = KP_RELEASE;

    logic [1:0]        r_state;
    logic [CIDX_W-1:0] r_col;
    logic [RIDX_W-1:0] r_row;
    logic [ROWS-1:0]   r_pattern;
    logic [SET_W-1:0]  r_settle;
    logic [DB_W-1:0]   r_cnt;

    logic [RIDX_W:0]   w_low_n;
    logic [RIDX_W-1:0] w_low_idx;
    logic              w_all_high;
    logic              w_one_low;
    logic              w_match;
    logic [CIDX_W-1:0] w_col_next;
    logic [CODE_W-1:0] w_code;
    logic              w_press_push;
    logic              w_push;
    logic [EVT_W-1:0]  w_push_data;
    logic [EVT_W-1:0]  w_head;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;

    // Count closed rows on the driven column and remember which one
    always_comb begin
        w_low_n   = '0;
        w_low_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_in[r]) begin
                w_low_n   = w_low_n + 1'b1;
                w_low_idx = RIDX_W'(r);
            end
        end
    end

    assign w_all_high   = &row_in;
    assign w_one_low    = (w_low_n == (RIDX_W + 1)'(1));
    assign w_match      = (row_in == r_pattern);
    assign w_col_next   = (r_col == CIDX_W'(COLS - 1)) ? '0 : r_col + 1'b1;
    assign w_code       = CODE_W'(kp_code(int'(r_row), int'(r_col), COLS));
    assign w_press_push = (r_state == c_ST_DEBOUNCE) && w_match &&
                          (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

    assign col_out = ~(COLS'(1) << r_col);
    assign busy    = (r_state != c_ST_SCAN);

    // Scan / debounce / hold / release sequencing; column stays parked while a key is tracked
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= c_ST_SCAN;
            r_col     <= '0;
            r_row     <= '0;
            r_pattern <= '1;
            r_settle  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                c_ST_SCAN: begin
                    if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
                        r_settle <= '0;
                        if (w_one_low) begin
                            r_row     <= w_low_idx;
                            r_pattern <= row_in;
                            r_cnt     <= '0;
                            r_state   <= c_ST_DEBOUNCE;
                        end else begin
                            // idle column, or several rows low (ghost): move on silently
                            r_col <= w_col_next;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (!w_match) begin
                        r_state <= c_ST_SCAN;
                        r_col   <= w_col_next;
                    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_state <= c_ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_HELD: begin
                    if (w_all_high) begin
                        r_state <= c_ST_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                c_ST_RELEASE: begin
                    if (!w_all_high) begin
                        r_state <= c_ST_HELD;
                    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_state <= c_ST_SCAN;
                        r_col   <= w_col_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_SCAN;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt;
    logic             r_rpt_armed;
    logic             w_rpt_fire;

    assign w_rpt_fire = (r_state == c_ST_HELD) && !w_all_high &&
                        (r_rpt_armed ? (r_rpt == RPT_W'(REPEAT_PERIOD - 1))
                                     : (r_rpt == RPT_W'(REPEAT_DELAY - 1)));

    // Held-time counter; restarts only on a fresh press so release bounce keeps the cadence
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_rpt       <= '0;
            r_rpt_armed <= 1'b0;
        end else if (w_press_push) begin
            r_rpt       <= '0;
            r_rpt_armed <= 1'b0;
        end else if (w_rpt_fire) begin
            r_rpt       <= '0;
            r_rpt_armed <= 1'b1;
        end else if ((r_state == c_ST_HELD) && !w_all_high) begin
            r_rpt <= r_rpt + 1'b1;
        end
    end

    assign w_push      = w_press_push || w_rpt_fire;
    assign w_push_data = {w_code, w_rpt_fire};
    assign evt_repeat  = w_head[0];
`else
    assign w_push      = w_press_push;
    assign w_push_data = w_code;
    assign evt_repeat  = 1'b0;
`endif

    assign evt_valid = !w_empty;
    assign w_pop     = evt_valid && evt_ready;
    assign w_drop    = w_push && w_full && !w_pop;
    assign evt_code  = w_head[EVT_W-1 -: CODE_W];

    keypad_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (RST),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (fifo_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire
